mux157_nibble_collector: RTL
============================

// Module: mux157_nibble_collector
// PURPOSE
//   Sequencer and capture register that sits directly downstream of a 74LVC157
//   quad 2:1 mux. It drives the mux S and nE pins and picks one source per
//   nibble beat. After each settle window it samples the 4-bit mux output and
//   shifts it into a wide word.
//   The assembled word goes to the next stage over a valid/ready handshake.
// PARAMETERS
//   NIBBLES        8  number of 4-bit beats per word; out_data is 4*NIBBLES bits
//   SETTLE_CYCLES  2  clk cycles between a mux_s/mux_ne change and the sample of
//                     mux_y (>=1; covers the 7 ns mux delay)
// PORTS
//   clk        in   1          single clock, all state on rising edge
//   rst        in   1          synchronous reset, active-high
//   start      in   1          request a word capture (honoured only in IDLE)
//   sel_mask   in   NIBBLES    per-beat select; bit k drives mux_s for beat k
//   mux_s      out  1          to 74LVC157 S (0=i0, 1=i1)
//   mux_ne     out  1          to 74LVC157 nE (active-low enable)
//   mux_y      in   4          from 74LVC157 y
//   busy       out  1          high whenever state != IDLE
//   out_valid  out  1          assembled word available
//   out_ready  in   1          consumer accepts word
//   out_data   out  4*NIBBLES  assembled word; beat 0 in bits [3:0]
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset values: state=IDLE, mux_s=0, mux_ne=1, busy=0, out_valid=0,
//     out_data=0, beat index=0, settle counter=0.
//   - States: IDLE, SETTLE, DONE.
//   - IDLE: mux_ne=1 and mux_s=0.
//     On start=1, at that edge: latch sel_mask, clear out_data, set idx=0,
//     mux_s=sel_mask[0], mux_ne=0, cnt=SETTLE_CYCLES-1, and go to SETTLE.
//   - SETTLE while cnt!=0: decrement cnt; mux_s/mux_ne held.
//   - SETTLE at cnt==0: write mux_y into out_data[4*idx+:4].
//     - If idx<NIBBLES-1: idx++, mux_s=latched_mask[idx+1], reload cnt.
//     - If idx==NIBBLES-1: mux_ne=1, mux_s=0, out_valid=1, go to DONE.
//   - Timing: start accepted at edge 0; beat k is sampled at edge
//     (k+1)*SETTLE_CYCLES. out_valid is first high after edge
//     NIBBLES*SETTLE_CYCLES (NIBBLES=8, SETTLE=2 -> 16 cycles).
//   - DONE: out_data and out_valid held stable until out_ready=1.
//     On that edge: out_valid=0, go to IDLE. out_data keeps its value until the
//     next start.
//   - start is ignored in SETTLE and DONE, including start together with
//     out_ready in DONE. A new capture needs start in IDLE, so at least one
//     IDLE cycle separates words.
//   - sel_mask changes after acceptance have no effect; the latched copy is used.
//   - mux_y is sampled only at cnt==0 in SETTLE and ignored at all other times.
//   - rst=1 in any state, including mid-beat, forces the reset values at that
//     edge. A partial word is discarded and the mux is disabled the next cycle.
//   - Counter width: $clog2(SETTLE_CYCLES+1). Index width: $clog2(NIBBLES), min 1.
// TESTING (bench uses a behavioural 157 with #7 delay, clk period 20 ns)
//   1 i0=4'h5, i1=4'hA, sel_mask=8'hAA, start pulse, out_ready=1
//     -> out_valid high after 16 cycles, out_data=32'hA5A5A5A5, 1-cycle valid.
//   2 Same run with out_ready=0 for 5 cycles and start=1 throughout DONE
//     -> out_valid/out_data stable for 5 cycles; no new capture until IDLE.
//   3 rst pulse during beat 3
//     -> next cycle: mux_ne=1, busy=0, out_valid=0, out_data=0; then a fresh
//        start completes normally.
//   4 sel_mask=8'h0F at start, changed to 8'hF0 on cycle 2; extra start pulses
//     mid-op -> out_data=32'h5555AAAA, one word only.
//   5 SETTLE_CYCLES=1, sel_mask=8'hFF, i1=4'h3 -> out_data=32'h33333333, valid
//     exactly 8 cycles after start.
//   6 Idle check: no start for 10 cycles -> mux_ne=1, mux_s=0, busy=0 every cycle.

Source files
------------

// File: rtl/mux157_nibble_collector_if.sv
// rtl/mux157_nibble_collector_if.sv - mux pin and word handshake bundle for the nibble collector
`timescale 1ns/1ps
interface mux157_nibble_collector_if #(
    parameter int NIBBLES = 8
);
    logic                   start;
    logic [NIBBLES-1:0]     sel_mask;
    logic                   mux_s;
    logic                   mux_ne;
    logic [3:0]             mux_y;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NIBBLES-1:0]   out_data;

    modport master (
        input  start, sel_mask, mux_y, out_ready,
        output mux_s, mux_ne, busy, out_valid, out_data
    );

    modport slave (
        output start, sel_mask, mux_y, out_ready,
        input  mux_s, mux_ne, busy, out_valid, out_data
    );
endinterface

// File: rtl/mux157_nibble_collector.sv
// rtl/mux157_nibble_collector.sv - sequences a 74LVC157 and assembles sampled nibbles into a word
`timescale 1ns/1ps
module mux157_nibble_collector #(
    parameter int NIBBLES       = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    mux157_nibble_collector_if.master bus
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t             state;
    logic [NIBBLES-1:0] mask;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      idx_next;
    logic [IW+1:0]      base;
    logic [CW-1:0]      cnt;

    assign idx_next = idx + IW'(1);
    assign base     = {idx, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mask          <= '0;
            idx           <= '0;
            cnt           <= '0;
            bus.mux_s     <= 1'b0;
            bus.mux_ne    <= 1'b1;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mask         <= bus.sel_mask;
                        bus.out_data <= '0;
                        idx          <= '0;
                        bus.mux_s    <= bus.sel_mask[0];
                        bus.mux_ne   <= 1'b0;
                        cnt          <= CNT_RELOAD;
                        bus.busy     <= 1'b1;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        // mux_y has had SETTLE_CYCLES edges to follow the last S/nE change
                        bus.out_data[base +: 4] <= bus.mux_y;
                        if (idx != IDX_LAST) begin
                            idx       <= idx_next;
                            bus.mux_s <= mask[idx_next];
                            cnt       <= CNT_RELOAD;
                        end else begin
                            bus.mux_ne    <= 1'b1;
                            bus.mux_s     <= 1'b0;
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.busy   <= 1'b0;
                    bus.mux_ne <= 1'b1;
                    bus.mux_s  <= 1'b0;
                end
            endcase
        end
    end
endmodule
